msdf_otf_converter: RTL and testbench

Downstream consumer of msdf_mult. Takes the serial MSD-first signed-digit product stream `p` and performs on-the-fly conversion into a conventional two's-complement word. It needs no carry-propagate adder. It frames N digits per result and presents the result with a valid/ready handshake to the parallel datapath.

---
 rtl/msdf_pkg.sv | 14 +
 rtl/msdf_otf_converter_otf_step.sv | 34 +++
 rtl/msdf_otf_converter.sv | 117 +++++++++++
 tb/tb_msdf_otf_converter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msdf_pkg.sv
// Shared signed-digit encodings and converter state encoding for the MSDF datapath.
package msdf_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } otf_state_e;

endpackage

// File: rtl/msdf_otf_converter_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q / QM pair (QM = Q - 1).
module otf_step
    import msdf_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        case (digit)
            DIG_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            // 2'b11 is not a legal digit and converts as zero
            default: begin
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/msdf_otf_converter.sv
// Frames N MSD-first signed digits into an (N+1)-bit two's-complement result via on-the-fly conversion.
// Optional sticky illegal-digit flag (digit_err) enabled by MSDF_OTF_DIGIT_CHECK_EN.
module msdf_otf_converter
    import msdf_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
`ifdef MSDF_OTF_DIGIT_CHECK_EN
    output logic         digit_err,
`endif
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [1:0]   in_digit,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   res
);

    localparam int CW = $clog2(N + 1);

    otf_state_e     state_q, state_d;
    logic [N:0]     q_q, q_d;
    logic [N:0]     qm_q, qm_d;
    logic [N:0]     res_q, res_d;
    logic [CW-1:0]  count_q, count_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           take;
    logic [N:0]     q_seed, qm_seed;
    logic [N:0]     q_step, qm_step;
    logic [CW-1:0]  cnt_step;

    assign in_ready  = (state_q != DONE) || out_ready;
    assign out_valid = out_valid_q;
    assign res       = res_q;

    // A first digit always starts from the empty-fraction seed, which also covers restart.
    assign q_seed  = in_first ? '0 : q_q;
    assign qm_seed = in_first ? '1 : qm_q;

    otf_step #(.W(N + 1)) u_step (
        .q       (q_seed),
        .qm      (qm_seed),
        .digit   (in_digit),
        .q_next  (q_step),
        .qm_next (qm_step)
    );

    always_comb begin
        accept      = in_valid && in_ready;
        take        = accept && (in_first || (state_q == CONV));
        cnt_step    = in_first ? CW'(1) : count_q + CW'(1);
        state_d     = state_q;
        q_d         = q_q;
        qm_d        = qm_q;
        res_d       = res_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;

        if ((state_q == DONE) && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end

        if (take) begin
            q_d  = q_step;
            qm_d = qm_step;
            if (cnt_step == CW'(N)) begin
                state_d     = DONE;
                res_d       = q_step;
                out_valid_d = 1'b1;
                count_d     = '0;
            end else begin
                state_d     = CONV;
                count_d     = cnt_step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            q_q         <= '0;
            qm_q        <= '1;
            res_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            qm_q        <= qm_d;
            res_q       <= res_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MSDF_OTF_DIGIT_CHECK_EN
    logic digit_err_q, digit_err_d;

    assign digit_err   = digit_err_q;
    assign digit_err_d = digit_err_q || (accept && (in_digit == 2'b11));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_err_q <= 1'b0;
        end else begin
            digit_err_q <= digit_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Scoreboard bench for msdf_otf_converter at N=4; covers digit_err when MSDF_OTF_DIGIT_CHECK_EN is set.
module tb_msdf_otf_converter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_first;
    logic [1:0]   in_digit;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   res;
`ifdef MSDF_OTF_DIGIT_CHECK_EN
    logic         digit_err;
`endif

    int           tests  = 0;
    int           failed = 0;
    logic [N:0]   sb[$];

    always #5 clk = ~clk;

    msdf_otf_converter #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MSDF_OTF_DIGIT_CHECK_EN
        .digit_err (digit_err),
`endif
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_digit  (in_digit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    function automatic logic [1:0] enc(input int d);
        case (d)
            1:       enc = 2'b10;
            -1:      enc = 2'b01;
            2:       enc = 2'b11;
            default: enc = 2'b00;
        endcase
    endfunction

    // Advance one cycle; any result handed off in this cycle is checked against the scoreboard.
    task automatic tick();
        logic [N:0] e;
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected: res=%0d, no result expected", $signed(res));
            end else begin
                e = sb.pop_front();
                if (res !== e) begin
                    failed++;
                    $display("FAIL sb_res: got %0d (%b), want %0d (%b)", $signed(res), res, $signed(e), e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input int d);
        in_valid = v;
        in_first = f;
        in_digit = enc(d);
        tick();
    endtask

    task automatic finish_frame(input string name, input int exp);
        in_valid = 1'b0;
        in_first = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("FAIL %s_latency: out_valid=%b, want 1", name, out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s_pulse: out_valid=%b, want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_digit = 2'b00; out_ready = 1'b1;
        #12;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 5'b00000) begin
            failed++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b res=%b, want 1 0 00000", in_ready, out_valid, res);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 5'b00000) begin
            failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b res=%b, want 1 0 00000", in_ready, out_valid, res);
        end
    endtask

    task automatic test_frames();
        int tbl[4][5] = '{
            '{ 1,  0,  1,  1,  11},
            '{ 1, -1,  0, -1,   3},
            '{-1,  0,  0,  0,  -8},
            '{ 0,  0,  0, -1,  -1}
        };
        for (int i = 0; i < 4; i++) begin
            sb.push_back(5'(tbl[i][4]));
            for (int k = 0; k < 4; k++) drive(1'b1, k == 0, tbl[i][k]);
            finish_frame("frame", tbl[i][4]);
        end
        // a stray non-first digit while idle must be dropped
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b0, 1);
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        sb.push_back(5'b01111);
        for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1);
        in_valid = 1'b0;
        in_first = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || res !== 5'b01111 || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL stall_hold: out_valid=%b res=%b in_ready=%b, want 1 01111 0", out_valid, res, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_first = 1'b1;
        in_digit = enc(-1);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failed++;
            $display("FAIL release_ready: in_ready=%b out_valid=%b, want 1 1", in_ready, out_valid);
        end
        sb.push_back(5'b10001);
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL release_drop: out_valid=%b, want 0", out_valid);
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, -1);
        tests++;
        if (res !== 5'b10001) begin
            failed++;
            $display("FAIL b2b_res: res=%b, want 10001", res);
        end
        finish_frame("b2b", -15);
    endtask

    task automatic test_restart();
        sb.push_back(5'b11001);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, -1);
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1);
        finish_frame("restart", -7);
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 1);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || res !== 5'b00000 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL midreset: out_valid=%b res=%b in_ready=%b, want 0 00000 1", out_valid, res, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        sb.push_back(5'b00100);
        drive(1'b1, 1'b1, 0);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        finish_frame("after_reset", 4);
    endtask

    task automatic test_digit_check();
        sb.push_back(5'b01000);
        drive(1'b1, 1'b1, 1);
`ifdef MSDF_OTF_DIGIT_CHECK_EN
        tests++;
        if (digit_err !== 1'b0) begin
            failed++;
            $display("FAIL digit_err_early: digit_err=%b, want 0", digit_err);
        end
`endif
        drive(1'b1, 1'b0, 2);
`ifdef MSDF_OTF_DIGIT_CHECK_EN
        tests++;
        if (digit_err !== 1'b1) begin
            failed++;
            $display("FAIL digit_err_set: digit_err=%b, want 1", digit_err);
        end
`endif
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        finish_frame("digit11", 8);
`ifdef MSDF_OTF_DIGIT_CHECK_EN
        tick();
        tests++;
        if (digit_err !== 1'b1) begin
            failed++;
            $display("FAIL digit_err_sticky: digit_err=%b, want 1", digit_err);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (digit_err !== 1'b0) begin
            failed++;
            $display("FAIL digit_err_clear: digit_err=%b, want 0", digit_err);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_restart();
        test_reset_mid_frame();
        test_digit_check();
        tick();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb_leftover: %0d results outstanding, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
